// File: rtl/axi_ram.sv
// AXI4 single-port-style RAM with independent write and read burst engines.
// Optional build macro AXI_RAM_READ_PIPELINE_EN adds one register stage on the read data path.
module axi_ram #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 16,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ID_WIDTH-1:0]   awid,
    input  logic [ADDR_WIDTH-1:0] awaddr,
    input  logic [7:0]            awlen,
    input  logic [2:0]            awsize,
    input  logic [1:0]            awburst,
    input  logic                  awlock,
    input  logic [3:0]            awcache,
    input  logic [2:0]            awprot,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [STRB_WIDTH-1:0] wstrb,
    input  logic                  wlast,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [ID_WIDTH-1:0]   bid,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [ID_WIDTH-1:0]   arid,
    input  logic [ADDR_WIDTH-1:0] araddr,
    input  logic [7:0]            arlen,
    input  logic [2:0]            arsize,
    input  logic [1:0]            arburst,
    input  logic                  arlock,
    input  logic [3:0]            arcache,
    input  logic [2:0]            arprot,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [ID_WIDTH-1:0]   rid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [1:0]            rresp,
    output logic                  rlast,
    output logic                  rvalid,
    input  logic                  rready
);

    localparam int WORD_LSB = $clog2(STRB_WIDTH);
    localparam int WORD_AW  = ADDR_WIDTH - WORD_LSB;
    localparam int DEPTH    = 1 << WORD_AW;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    // WRAP keeps the upper address bits and lets only the window offset roll over.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        case (burst)
            BURST_FIXED: next_addr = addr;
            BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
            default:     next_addr = addr + step;
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic                  unused_inputs;
    assign unused_inputs = ^{awlock, awcache, awprot, arlock, arcache, arprot, wlast};

    // ---------------- write engine ----------------
    logic [1:0]            wstate_q, wstate_d;
    logic [ID_WIDTH-1:0]   awid_q, awid_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [2:0]            wsize_q, wsize_d;
    logic [1:0]            wburst_q, wburst_d;
    logic [7:0]            wcnt_q, wcnt_d;
    logic                  awready_q, wready_q, bvalid_q;
    logic                  mem_we;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        wstate_d = wstate_q;
        awid_d   = awid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wsize_d  = wsize_q;
        wburst_d = wburst_q;
        wcnt_d   = wcnt_q;
        mem_we   = 1'b0;
        case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready_q) begin
                    wstate_d = W_DATA;
                    awid_d   = awid;
                    waddr_d  = awaddr;
                    wlen_d   = awlen;
                    wsize_d  = awsize;
                    wburst_d = awburst;
                    wcnt_d   = 8'd0;
                end
            end
            W_DATA: begin
                if (wvalid && wready_q) begin
                    mem_we  = 1'b1;
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (wcnt_q == wlen_q) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wstate_q  <= W_IDLE;
            awid_q    <= '0;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wsize_q   <= '0;
            wburst_q  <= '0;
            wcnt_q    <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            awid_q    <= awid_d;
            waddr_q   <= waddr_d;
            wlen_q    <= wlen_d;
            wsize_q   <= wsize_d;
            wburst_q  <= wburst_d;
            wcnt_q    <= wcnt_d;
            awready_q <= (wstate_d == W_IDLE);
            wready_q  <= (wstate_d == W_DATA);
            bvalid_q  <= (wstate_d == W_RESP);
        end
    end

    // NOTE: storage is deliberately left out of reset so contents survive an aborted burst.
    always_ff @(posedge aclk) begin
        if (aresetn && mem_we) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (wstrb[b]) mem_q[waddr_q[ADDR_WIDTH-1:WORD_LSB]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // ---------------- read engine ----------------
    logic [0:0]            rstate_q, rstate_d;
    logic [ID_WIDTH-1:0]   rid_q, rid_d;
    logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [2:0]            rsize_q, rsize_d;
    logic [1:0]            rburst_q, rburst_d;
    logic [7:0]            rcnt_q, rcnt_d;
    logic                  arready_q, rvalid_q, rlast_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rd_fetch;
    logic                  fetch_last;
    logic [WORD_AW-1:0]    rd_word;

    // raddr_q always points at the beat after the one being fetched.
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rsize_d  = rsize_q;
        rburst_d = rburst_q;
        rcnt_d   = rcnt_q;
        rd_fetch = 1'b0;
        rd_word  = raddr_q[ADDR_WIDTH-1:WORD_LSB];
        case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    rstate_d = R_DATA;
                    rid_d    = arid;
                    rlen_d   = arlen;
                    rsize_d  = arsize;
                    rburst_d = arburst;
                    rcnt_d   = 8'd0;
                    rd_fetch = 1'b1;
                    rd_word  = araddr[ADDR_WIDTH-1:WORD_LSB];
                    raddr_d  = next_addr(araddr, arlen, arsize, arburst);
                end
            end
            R_DATA: begin
                if (rvalid_q && rready) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                    end else begin
                        rd_fetch = 1'b1;
                        raddr_d  = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        rcnt_d   = rcnt_q + 8'd1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        fetch_last = (rcnt_d == rlen_d);
    end

`ifdef AXI_RAM_READ_PIPELINE_EN
    logic                  fetch_q;
    logic [DATA_WIDTH-1:0] pdata_q;
    logic                  plast_q;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rstate_q  <= R_IDLE;
            rid_q     <= '0;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rsize_q   <= '0;
            rburst_q  <= '0;
            rcnt_q    <= '0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef AXI_RAM_READ_PIPELINE_EN
            fetch_q   <= 1'b0;
            pdata_q   <= '0;
            plast_q   <= 1'b0;
`endif
        end else begin
            rstate_q  <= rstate_d;
            rid_q     <= rid_d;
            raddr_q   <= raddr_d;
            rlen_q    <= rlen_d;
            rsize_q   <= rsize_d;
            rburst_q  <= rburst_d;
            rcnt_q    <= rcnt_d;
            arready_q <= (rstate_d == R_IDLE);
`ifdef AXI_RAM_READ_PIPELINE_EN
            fetch_q <= rd_fetch;
            if (rd_fetch) begin
                pdata_q <= mem_q[rd_word];
                plast_q <= fetch_last;
            end
            if (fetch_q) begin
                rdata_q  <= pdata_q;
                rlast_q  <= plast_q;
                rvalid_q <= 1'b1;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
`else
            // A read that collides with a write on the same edge sees the old word.
            if (rd_fetch) begin
                rdata_q  <= mem_q[rd_word];
                rlast_q  <= fetch_last;
                rvalid_q <= 1'b1;
            end else if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
`endif
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bid     = awid_q;
    assign bresp   = 2'b00;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = 2'b00;
    assign rlast   = rlast_q;

endmodule

// File: tb/tb_axi_ram.sv
// Self-checking bench for axi_ram: table-driven single-beat vectors plus burst,
// backpressure, collision and reset-abort sequences, with a read-beat scoreboard.
module tb_axi_ram;

    localparam int TIMEOUT = 50;
`ifdef AXI_RAM_READ_PIPELINE_EN
    localparam int RD_LAT = 2;
`else
    localparam int RD_LAT = 1;
`endif

    logic         aclk;
    logic         aresetn;
    logic [7:0]   awid;
    logic [15:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic         awvalid;
    logic         awready;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         wlast;
    logic         wvalid;
    logic         wready;
    logic [7:0]   bid;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready;
    logic [7:0]   arid;
    logic [15:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;
    logic [7:0]   rid;
    logic [127:0] rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    axi_ram dut (
        .aclk(aclk), .aresetn(aresetn),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(1'b0), .awcache(4'd0), .awprot(3'd0), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(1'b0), .arcache(4'd0), .arprot(3'd0), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [127:0] data;
        logic [7:0]   id;
        logic         last;
    } rbeat_t;

    typedef struct {
        logic [15:0]  addr;
        logic [7:0]   id;
        logic [15:0]  strb;
        logic [127:0] data;
        logic [127:0] exp;
    } vec_t;

    rbeat_t       rq[$];
    logic [7:0]   bq[$];
    logic [127:0] model_mem [int];
    logic [127:0] wbeats [0:15];
    vec_t         vecs [0:6];
    int           checks = 0;
    int           failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent byte-address model: window base by division, offset by modulo.
    function automatic logic [15:0] model_next(input logic [15:0] a, input logic [7:0] len,
                                               input logic [2:0] size, input logic [1:0] burst);
        int unsigned step, win, base, off;
        step = 1 << size;
        win  = (int'(len) + 1) * step;
        case (burst)
            2'b00: return a;
            2'b10: begin
                base = (int'(a) / win) * win;
                off  = (int'(a) - base + step) % win;
                return 16'(base + off);
            end
            default: return 16'((int'(a) + step) % 65536);
        endcase
    endfunction

    function automatic logic [127:0] model_read(input logic [15:0] a);
        int idx = int'(a) >> 4;
        return model_mem.exists(idx) ? model_mem[idx] : '0;
    endfunction

    task automatic model_write(input logic [15:0] a, input logic [127:0] d, input logic [15:0] s);
        logic [127:0] w;
        w = model_read(a);
        for (int b = 0; b < 16; b++) if (s[b]) w[b*8 +: 8] = d[b*8 +: 8];
        model_mem[int'(a) >> 4] = w;
    endtask

    task automatic push_model_beats(input logic [15:0] addr, input logic [7:0] len,
                                    input logic [2:0] size, input logic [1:0] burst, input logic [7:0] id);
        logic [15:0] a;
        a = addr;
        for (int i = 0; i <= int'(len); i++) begin
            rq.push_back('{data: model_read(a), id: id, last: (i == int'(len))});
            a = model_next(a, len, size, burst);
        end
    endtask

    task automatic issue_aw(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id);
        int n;
        @(negedge aclk);
        awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
        n = 0;
        while (awready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
        check("awready", awready, 1);
        bq.push_back(id);
        @(negedge aclk);
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [15:0] strb, input int nbeats);
        logic [15:0] a;
        int n;
        a = addr;
        for (int i = 0; i < nbeats; i++) begin
            wdata = wbeats[i]; wstrb = strb; wlast = (i == int'(len)); wvalid = 1'b1;
            n = 0;
            while (wready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
            check($sformatf("wready[%0d]", i), wready, 1);
            model_write(a, wbeats[i], strb);
            a = model_next(a, len, size, burst);
            @(negedge aclk);
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic collect_b();
        int n;
        logic [7:0] exp_id;
        n = 0;
        while (bvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
        check("bvalid", bvalid, 1);
        exp_id = (bq.size() > 0) ? bq.pop_front() : 8'hxx;
        check("bid", bid, exp_id);
        check("bresp", bresp, 0);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        check("awready_after_b", awready, 1);
        check("bvalid_clear", bvalid, 0);
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id, input logic [15:0] strb);
        issue_aw(addr, len, size, burst, id);
        send_w(addr, len, size, burst, strb, int'(len) + 1);
        collect_b();
    endtask

    task automatic issue_ar(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] id);
        int n;
        @(negedge aclk);
        araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
        n = 0;
        while (arready !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
        check("arready", arready, 1);
        @(negedge aclk);
        arvalid = 1'b0;
    endtask

    task automatic collect_r(input int nbeats, input int stall_beat, input int stall_cycles);
        int n;
        rbeat_t e;
        for (int b = 0; b < nbeats; b++) begin
            rready = 1'b1;
            n = 0;
            while (rvalid !== 1'b1 && n < TIMEOUT) begin @(negedge aclk); n++; end
            check(b == 0 ? "ar_to_rvalid_latency" : "beat_latency", n + 1, RD_LAT);
            e = (rq.size() > 0) ? rq.pop_front() : '{data: 'x, id: 'x, last: 1'bx};
            if (b == stall_beat) begin
                rready = 1'b0;
                repeat (stall_cycles) begin
                    @(negedge aclk);
                    check("stall_rvalid", rvalid, 1);
                    check("stall_rdata", rdata, e.data);
                    check("stall_rlast", rlast, e.last);
                end
                rready = 1'b1;
            end
            check($sformatf("rdata[%0d]", b), rdata, e.data);
            check($sformatf("rid[%0d]", b), rid, e.id);
            check($sformatf("rlast[%0d]", b), rlast, e.last);
            check("rresp", rresp, 0);
            @(negedge aclk);
        end
        rready = 1'b0;
        check("arready_after_last", arready, 1);
        check("rvalid_clear", rvalid, 0);
    endtask

    task automatic do_read(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [7:0] id);
        push_model_beats(addr, len, size, burst, id);
        issue_ar(addr, len, size, burst, id);
        collect_r(int'(len) + 1, -1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary expected completion before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h0010, 8'h05, 16'hFFFF, 128'h0123456789ABCDEF0123456789ABCDEF,
                    128'h0123456789ABCDEF0123456789ABCDEF};
        vecs[1] = '{16'h0010, 8'h06, 16'h000F, {16{8'hAA}},
                    128'h0123456789ABCDEF01234567AAAAAAAA};
        vecs[2] = '{16'h0020, 8'h10, 16'hFFFF, 128'hDEADBEEF_CAFEF00D_0F1E2D3C_4B5A6978,
                    128'hDEADBEEF_CAFEF00D_0F1E2D3C_4B5A6978};
        vecs[3] = '{16'h0020, 8'h11, 16'hF000, 128'h11111111_22222222_33333333_44444444,
                    128'h11111111_CAFEF00D_0F1E2D3C_4B5A6978};
        vecs[4] = '{16'h002C, 8'h12, 16'h00F0, {16{8'h55}},
                    128'h11111111_CAFEF00D_55555555_4B5A6978};
        vecs[5] = '{16'hFFF0, 8'h13, 16'hFFFF, 128'hFEDCBA98_76543210_00000000_FFFFFFFF,
                    128'hFEDCBA98_76543210_00000000_FFFFFFFF};
        vecs[6] = '{16'h0010, 8'h14, 16'h0000, {16{8'hFF}},
                    128'h0123456789ABCDEF01234567AAAAAAAA};

        aresetn = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;

        repeat (3) @(negedge aclk);
        check("rst_awready", awready, 0);
        check("rst_wready", wready, 0);
        check("rst_bvalid", bvalid, 0);
        check("rst_arready", arready, 0);
        check("rst_rvalid", rvalid, 0);
        check("rst_rlast", rlast, 0);
        check("rst_bid", bid, 0);
        check("rst_bresp", bresp, 0);
        check("rst_rid", rid, 0);
        check("rst_rresp", rresp, 0);
        check("rst_rdata", rdata, 0);
        aresetn = 1'b1;
        @(negedge aclk);
        check("rel_awready", awready, 1);
        check("rel_arready", arready, 1);
        check("rel_bvalid", bvalid, 0);
        check("rel_rvalid", rvalid, 0);

        for (int i = 0; i < 7; i++) begin
            wbeats[0] = vecs[i].data;
            do_write(vecs[i].addr, 8'd0, 3'd4, 2'b01, vecs[i].id, vecs[i].strb);
            rq.push_back('{data: vecs[i].exp, id: 8'(vecs[i].id + 8'h02), last: 1'b1});
            issue_ar(vecs[i].addr, 8'd0, 3'd4, 2'b01, 8'(vecs[i].id + 8'h02));
            collect_r(1, -1, 0);
        end

        // INCR burst, then read back with a 5-cycle rready stall on beat 1.
        for (int i = 0; i < 4; i++) wbeats[i] = 128'(i + 1);
        do_write(16'h0100, 8'd3, 3'd4, 2'b01, 8'h20, 16'hFFFF);
        push_model_beats(16'h0100, 8'd3, 3'd4, 2'b01, 8'h21);
        issue_ar(16'h0100, 8'd3, 3'd4, 2'b01, 8'h21);
        collect_r(4, 1, 5);

        // FIXED burst: both beats land on one word.
        wbeats[0] = 128'h11; wbeats[1] = 128'h22;
        do_write(16'h0600, 8'd1, 3'd4, 2'b00, 8'h30, 16'hFFFF);
        do_read(16'h0600, 8'd0, 3'd4, 2'b01, 8'h31);

        // WRAP burst starting mid-window, read linearly and with a wrapping read.
        for (int i = 0; i < 4; i++) wbeats[i] = {4{32'hA0A0_0000 + 32'(i)}};
        do_write(16'h0430, 8'd3, 3'd4, 2'b10, 8'h40, 16'hFFFF);
        do_read(16'h0400, 8'd3, 3'd4, 2'b01, 8'h41);
        do_read(16'h0420, 8'd3, 3'd4, 2'b10, 8'h42);

        // Reserved burst type behaves as INCR.
        wbeats[0] = {8{16'hBEEF}}; wbeats[1] = {8{16'hF00D}};
        do_write(16'h0500, 8'd1, 3'd4, 2'b11, 8'h50, 16'hFFFF);
        do_read(16'h0500, 8'd1, 3'd4, 2'b01, 8'h51);

        // Address wraps past the top of the map.
        wbeats[0] = {4{32'h1357_9BDF}}; wbeats[1] = {4{32'h2468_ACE0}};
        do_write(16'hFFF0, 8'd1, 3'd4, 2'b01, 8'h60, 16'hFFFF);
        do_read(16'hFFF0, 8'd1, 3'd4, 2'b01, 8'h61);

        // Read and write of one word on the same edge: read returns old data.
        wbeats[0] = {16{8'h3C}};
        do_write(16'h0300, 8'd0, 3'd4, 2'b01, 8'h70, 16'hFFFF);
        issue_aw(16'h0300, 8'd0, 3'd4, 2'b01, 8'h71);
        push_model_beats(16'h0300, 8'd0, 3'd4, 2'b01, 8'h72);
        araddr = 16'h0300; arlen = 8'd0; arsize = 3'd4; arburst = 2'b01; arid = 8'h72; arvalid = 1'b1;
        wdata = {16{8'hC3}}; wstrb = 16'hFFFF; wlast = 1'b1; wvalid = 1'b1;
        check("collide_arready", arready, 1);
        check("collide_wready", wready, 1);
        model_write(16'h0300, {16{8'hC3}}, 16'hFFFF);
        @(negedge aclk);
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        collect_r(1, -1, 0);
        collect_b();
        do_read(16'h0300, 8'd0, 3'd4, 2'b01, 8'h73);

        // Reset mid-burst: two of four beats written, then abort.
        for (int i = 0; i < 4; i++) wbeats[i] = {4{32'h7700_0000 + 32'(i)}};
        issue_aw(16'h0200, 8'd3, 3'd4, 2'b01, 8'h80);
        send_w(16'h0200, 8'd3, 3'd4, 2'b01, 16'hFFFF, 2);
        aresetn = 1'b0;
        bq.delete();
        @(negedge aclk);
        check("abort_awready", awready, 0);
        check("abort_wready", wready, 0);
        check("abort_bvalid", bvalid, 0);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check("abort_rel_awready", awready, 1);
        check("abort_rel_wready", wready, 0);
        do_read(16'h0200, 8'd1, 3'd4, 2'b01, 8'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_ram.md
AXI_RAM -- requirements
Module: axi_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128: data bus width in bits, power of two, 8..1024.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: byte address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: byte-strobe width.
REQ-004 SHALL have parameter ID_WIDTH, default 8: transaction ID width.
REQ-005 SHALL declare parameters, then ports, in the order listed here.
REQ-006 aclk  in  1  single clock; all logic on the rising edge.
REQ-007 aresetn  in  1  reset, synchronous, active-low.
REQ-008 awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address, beat count-1, bytes-per-beat code, burst type.
REQ-009 awlock/awcache/awprot  in  1/4/3  accepted and ignored.
REQ-010 awvalid in 1, awready out 1  write-address handshake.
REQ-011 wdata/wstrb/wlast  in  DATA_WIDTH/STRB_WIDTH/1  write data, byte enables, last flag.
REQ-012 wvalid in 1, wready out 1  write-data handshake.
REQ-013 bid/bresp  out  ID_WIDTH/2  write response; bvalid out 1, bready in 1.
REQ-014 arid/araddr/arlen/arsize/arburst  in  same widths as AW  read address; arlock/arcache/arprot in 1/4/3, ignored.
REQ-015 arvalid in 1, arready out 1  read-address handshake.
REQ-016 rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1  read data; rvalid out 1, rready in 1.

Function
REQ-017 Storage SHALL be 2^(ADDR_WIDTH-log2(STRB_WIDTH)) words of DATA_WIDTH; word index = addr[ADDR_WIDTH-1:log2(STRB_WIDTH)].
REQ-018 Write FSM SHALL have states IDLE (awready=1), DATA (wready=1), RESP (bvalid=1); only one write burst in flight.
REQ-019 IDLE->DATA on awvalid&awready, latching id, addr, len, size, burst; awready deasserts the next cycle.
REQ-020 Each wvalid&wready beat SHALL write only the bytes whose wstrb bit is 1, then advance the address.
REQ-021 The burst SHALL end after awlen+1 beats, regardless of wlast. DATA->RESP then drives bvalid=1, bid=latched id, bresp=2'b00.
REQ-022 RESP->IDLE on bvalid&bready; awready SHALL be 1 in the following cycle.
REQ-023 Read FSM SHALL have states IDLE (arready=1) and DATA (rvalid=1); it SHALL be independent of the write FSM.
REQ-024 rdata for beat 0 SHALL be registered and valid the cycle after the AR handshake. Each following beat SHALL be valid the cycle after the previous rvalid&rready.
REQ-025 rid SHALL be the latched id, rresp 2'b00, and rlast=1 only on beat arlen.
REQ-026 While rvalid=1 and rready=0, rdata/rid/rlast SHALL hold stable.
REQ-027 Address advance: FIXED (00) keeps the address; INCR (01) adds 2^size.
REQ-028 WRAP (10) SHALL add 2^size, wrapping within an aligned (len+1)*2^size window.
REQ-029 Reserved burst type (11) SHALL behave as INCR.
REQ-030 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.
REQ-031 Same-cycle read and write to one word SHALL return the pre-write data.

Reset
REQ-032 While aresetn=0: awready, wready, bvalid, arready, rvalid, rlast = 0; bid, bresp, rid, rresp, rdata = 0; both FSMs go to IDLE.
REQ-033 awready and arready SHALL be 1 on the first rising edge after aresetn returns to 1.
REQ-034 Memory contents SHALL NOT be reset.
REQ-035 Reset asserted mid-burst SHALL abort the burst; bytes already written SHALL persist.

Configuration
REQ-036 With macro AXI_RAM_READ_PIPELINE_EN defined, read data SHALL pass one extra register stage, giving 2-cycle AR-to-first-rvalid latency and 2-cycle beat-to-beat latency under continuous rready.
REQ-037 Without AXI_RAM_READ_PIPELINE_EN, read timing SHALL be as in REQ-024.
REQ-038 Handshake rules SHALL be identical in both builds.

Verification (defaults: DATA 128, ADDR 16)
REQ-039 Reset: hold aresetn=0 -> all valid/ready outputs 0; release -> awready=arready=1 one edge later, bvalid=rvalid=0.
REQ-040 Single write: awaddr 0x0010, awlen 0, awid 0x05, wdata 0x0123..CDEF, wstrb 0xFFFF -> bvalid, bid 0x05, bresp 0.
REQ-041 Readback: araddr 0x0010, arid 0x07 -> rdata = the REQ-040 data, rid 0x07, rlast 1.
REQ-042 Partial strobe: write all-0xAA with wstrb 0x000F over the REQ-040 word -> readback shows only bytes 0-3 = 0xAA.
REQ-043 INCR burst: awaddr 0x0100, awlen 3, awsize 4, data 1..4 -> reads of 0x100/0x110/0x120/0x130 return 1..4; rlast only on beat 4.
REQ-044 Backpressure: rready=0 for 5 cycles mid-burst -> rvalid stays 1, rdata/rlast unchanged.
REQ-045 FIXED burst: awburst 00, awlen 1, beats 0x11, 0x22 -> single word reads 0x22.
